// File: rtl/rst_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : rst_sequencer_if
// Description : Control/status bundle of the reset release sequencer.
//               SW_RST       - synchronous active-high software reset request
//               DOMAIN_RST_N - staged active-low domain resets (bit 0 first)
//               RST_DONE     - high once every domain has been released
//               Modport slave is the sequencer side; master is the consumer
//               that issues software resets and watches the domain resets.
// Revision    : 1.0 - initial release
// ============================================================================
interface rst_sequencer_if #(
    parameter int NUM_DOMAINS = 3
);
    logic                   SW_RST;
    logic [NUM_DOMAINS-1:0] DOMAIN_RST_N;
    logic                   RST_DONE;

    modport master (
        output SW_RST,
        input  DOMAIN_RST_N,
        input  RST_DONE
    );

    modport slave (
        input  SW_RST,
        output DOMAIN_RST_N,
        output RST_DONE
    );
endinterface
`default_nettype wire

// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rst_sequencer
// Description : Reset release sequencer. After the synchronized reset RST
//               deasserts, all domain resets are held for HOLD_CYCLES edges,
//               then released one by one (lowest index first) every
//               STAGE_GAP edges. A software reset request restarts the whole
//               sequence from the hold phase.
// Ports       : CLK  - system clock, rising edge
//               RST  - asynchronous active-low reset (synchronized upstream)
//               bus  - rst_sequencer_if.slave (SW_RST in; DOMAIN_RST_N and
//                      RST_DONE out, both registered)
// Revision    : 1.0 - initial release
// ============================================================================
module rst_sequencer #(
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  wire logic        CLK,
    input  wire logic        RST,
    rst_sequencer_if.slave   bus
);

    localparam int CNT_MAX_VAL = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W       = $clog2(CNT_MAX_VAL + 1);
    localparam int IDX_W       = $clog2(NUM_DOMAINS + 1);

    // The counter is compared against target-1 so that the release happens
    // on the same edge at which the count would reach its target.
    localparam logic [CNT_W-1:0]       c_hold_last = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       c_gap_last  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0]       c_cnt_max   = '1;
    localparam logic [IDX_W-1:0]       c_last_idx  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] c_one       = NUM_DOMAINS'(1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_DOMAINS-1:0] r_dom_rst_n;
    logic                   r_done;
    logic [CNT_W-1:0]       w_cnt_inc;

    // Saturating increment: the counter never wraps even if a target were
    // somehow missed.
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_ASSERT;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_dom_rst_n <= '0;
            r_done      <= 1'b0;
        end else if (bus.SW_RST) begin
            // Software reset wins over any release due on this edge.
            r_state     <= ST_ASSERT;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_dom_rst_n <= '0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (r_cnt == c_hold_last) begin
                        r_dom_rst_n <= c_one;
                        r_cnt       <= '0;
                        if (NUM_DOMAINS == 1) begin
                            r_state <= ST_RUN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RELEASE;
                            r_idx   <= IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == c_gap_last) begin
                        // Shifting a one in from the bottom keeps the release
                        // monotonic: a bit can only rise after all lower bits.
                        r_dom_rst_n <= (r_dom_rst_n << 1) | c_one;
                        r_cnt       <= '0;
                        if (r_idx == c_last_idx) begin
                            r_state <= ST_RUN;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_RUN: begin
                    // Hold outputs until SW_RST or RST.
                end
                default: begin
                    r_state     <= ST_ASSERT;
                    r_cnt       <= '0;
                    r_idx       <= '0;
                    r_dom_rst_n <= '0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DOMAIN_RST_N = r_dom_rst_n;
    assign bus.RST_DONE     = r_done;

endmodule
`default_nettype wire
